// File: rtl/subleq_operand_fetch_if.sv
// Operand-fetch bus: start/pc request, busy/done status, memory read port
// and the operand-register load strobes with their shared data word.
interface subleq_operand_fetch_if #(
    parameter int WORD_SIZE = 16
);
    logic                 start;
    logic [WORD_SIZE-1:0] pc;
    logic                 busy;
    logic                 done;
    logic                 mem_rd;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_rdata;
    logic [WORD_SIZE-1:0] word_out;
    logic                 a_set;
    logic                 b_set;
    logic                 c_set;
    logic                 ma_set;
    logic                 mb_set;

    // Controller/memory side.
    modport master (
        output start, pc, mem_rdata,
        input  busy, done, mem_rd, mem_addr, word_out,
               a_set, b_set, c_set, ma_set, mb_set
    );

    // Fetch unit side.
    modport slave (
        input  start, pc, mem_rdata,
        output busy, done, mem_rd, mem_addr, word_out,
               a_set, b_set, c_set, ma_set, mb_set
    );
endinterface

// File: rtl/subleq_operand_fetch.sv
// SUBLEQ operand fetch: reads A, B, C at pc..pc+2 and then mem[A], mem[B].
// Read data returns one cycle after the strobe, so every load strobe lags
// its read by one state and the last one lands in FIN with no read.
module subleq_operand_fetch #(
    parameter int WORD_SIZE = 16
) (
    input  logic                   clk,
    input  logic                   areset,
    subleq_operand_fetch_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_B  = 3'd2,
        RD_C  = 3'd3,
        RD_MA = 3'd4,
        RD_MB = 3'd5,
        FIN   = 3'd6
    } state_t;

    state_t               state, state_nx;
    logic [WORD_SIZE-1:0] pc_q, a_q, b_q;
    logic [WORD_SIZE-1:0] pc_p1, pc_p2;
    logic                 any_set;

    // Address increments wrap naturally at the word width.
    assign pc_p1 = pc_q + WORD_SIZE'(1);
    assign pc_p2 = pc_q + WORD_SIZE'(2);

    // State register plus the request pc and the two pointer operands.
    always_ff @(posedge clk) begin
        if (areset) begin
            state <= IDLE;
            pc_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.start) pc_q <= bus.pc;
            if (state == RD_B)              a_q  <= bus.mem_rdata;
            if (state == RD_C)              b_q  <= bus.mem_rdata;
        end
    end

    // Next-state and state-decoded outputs; start only steers the next state.
    always_comb begin
        state_nx     = state;
        bus.busy     = 1'b1;
        bus.done     = 1'b0;
        bus.mem_rd   = 1'b0;
        bus.mem_addr = '0;
        bus.a_set    = 1'b0;
        bus.b_set    = 1'b0;
        bus.c_set    = 1'b0;
        bus.ma_set   = 1'b0;
        bus.mb_set   = 1'b0;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) state_nx = RD_A;
            end
            RD_A: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = pc_q;
                state_nx     = RD_B;
            end
            RD_B: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = pc_p1;
                bus.a_set    = 1'b1;
                state_nx     = RD_C;
            end
            RD_C: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = pc_p2;
                bus.b_set    = 1'b1;
                state_nx     = RD_MA;
            end
            RD_MA: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = a_q;
                bus.c_set    = 1'b1;
                state_nx     = RD_MB;
            end
            RD_MB: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = b_q;
                bus.ma_set   = 1'b1;
                state_nx     = FIN;
            end
            FIN: begin
                bus.mb_set = 1'b1;
                bus.done   = 1'b1;
                state_nx   = IDLE;
            end
            default: begin
                bus.busy = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    // Operand word is only meaningful alongside a load strobe.
    always_comb begin
        any_set      = bus.a_set | bus.b_set | bus.c_set | bus.ma_set | bus.mb_set;
        bus.word_out = any_set ? bus.mem_rdata : '0;
    end
endmodule

// File: tb/tb_subleq_operand_fetch.sv
// Bench for subleq_operand_fetch: memory responder, scoreboard queues for
// read addresses, load strobes and done timing, and scenario tasks.
module tb_subleq_operand_fetch;
    logic clk = 1'b0;
    logic areset = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    subleq_operand_fetch_if #(.WORD_SIZE(16)) bus ();
    subleq_operand_fetch #(.WORD_SIZE(16)) dut (.clk(clk), .areset(areset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] mem [0:65535];

    // Memory: data for a strobed address appears one cycle later.
    always @(posedge clk) bus.mem_rdata <= bus.mem_rd ? mem[bus.mem_addr] : 16'h0000;

    typedef struct {
        int          kind;
        logic [15:0] val;
    } stb_t;

    logic [15:0] addr_q [$];
    stb_t        stb_q  [$];
    int          done_q [$];

    // Expected reads/strobes of one fetch, derived from the bench memory.
    function automatic void push_fetch(input logic [15:0] p, input int c,
                                       input int nrd, input int nstb, input bit with_done);
        logic [15:0] adr [5];
        logic [15:0] val [5];
        logic [15:0] p1, p2;
        stb_t s;
        p1 = p + 16'd1;
        p2 = p + 16'd2;
        adr[0] = p;  adr[1] = p1; adr[2] = p2; adr[3] = mem[p]; adr[4] = mem[p1];
        val[0] = mem[p]; val[1] = mem[p1]; val[2] = mem[p2];
        val[3] = mem[mem[p]]; val[4] = mem[mem[p1]];
        for (int i = 0; i < nrd; i++) addr_q.push_back(adr[i]);
        for (int i = 0; i < nstb; i++) begin
            s.kind = i;
            s.val  = val[i];
            stb_q.push_back(s);
        end
        if (with_done) done_q.push_back(c + 6);
    endfunction

    // Per-cycle monitor sampled on the falling edge.
    always @(negedge clk) begin
        int   n, k;
        logic [15:0] ea;
        stb_t es;
        n = int'(bus.a_set) + int'(bus.b_set) + int'(bus.c_set) + int'(bus.ma_set) + int'(bus.mb_set);
        k = bus.a_set ? 0 : bus.b_set ? 1 : bus.c_set ? 2 : bus.ma_set ? 3 : 4;
        tests++;
        if (n > 1) begin fails++; $display("FAIL onehot cyc=%0d got %0d strobes, want <=1", cyc, n); end
        if (n == 0) begin
            tests++;
            if (bus.word_out !== 16'h0) begin fails++; $display("FAIL word_out_idle cyc=%0d got %h want 0000", cyc, bus.word_out); end
        end
        if (!bus.mem_rd) begin
            tests++;
            if (bus.mem_addr !== 16'h0) begin fails++; $display("FAIL addr_idle cyc=%0d got %h want 0000", cyc, bus.mem_addr); end
        end else begin
            tests++;
            if (addr_q.size() == 0) begin
                fails++; $display("FAIL unexpected_rd cyc=%0d addr %h, none expected", cyc, bus.mem_addr);
            end else begin
                ea = addr_q.pop_front();
                if (bus.mem_addr !== ea) begin fails++; $display("FAIL rd_addr cyc=%0d got %h want %h", cyc, bus.mem_addr, ea); end
            end
        end
        if (n == 1) begin
            tests++;
            if (stb_q.size() == 0) begin
                fails++; $display("FAIL unexpected_set cyc=%0d kind %0d, none expected", cyc, k);
            end else begin
                es = stb_q.pop_front();
                if (k !== es.kind || bus.word_out !== es.val) begin
                    fails++; $display("FAIL set cyc=%0d got kind %0d word %h want kind %0d word %h", cyc, k, bus.word_out, es.kind, es.val);
                end
            end
        end
        if (bus.done) begin
            tests++;
            if (done_q.size() == 0) begin
                fails++; $display("FAIL unexpected_done cyc=%0d", cyc);
            end else begin
                n = done_q.pop_front();
                if (cyc !== n) begin fails++; $display("FAIL done_cycle got %0d want %0d", cyc, n); end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (done_q.size() == 0 && stb_q.size() == 0 && addr_q.size() == 0 && bus.busy === 1'b0) ok = 1;
        end
        tests++;
        if (!ok) begin
            fails++; $display("FAIL %s_timeout pending done=%0d set=%0d rd=%0d want all 0", name, done_q.size(), stb_q.size(), addr_q.size());
            done_q.delete(); stb_q.delete(); addr_q.delete();
        end
    endtask

    task automatic check_quiet(input string name);
        logic [70:0] o;
        o = {bus.busy, bus.done, bus.mem_rd, bus.mem_addr, bus.word_out, bus.a_set, bus.b_set,
             bus.c_set, bus.ma_set, bus.mb_set, 20'h0, bus.mem_addr ^ bus.word_out};
        tests++;
        if (o !== 71'h0) begin fails++; $display("FAIL %s outputs got %h want 0", name, o); end
    endtask

    task automatic test_reset();
        bus.start = 1'b1;
        bus.pc    = 16'h1234;
        areset    = 1'b1;
        step();
        @(negedge clk);
        check_quiet("reset_state");
        step();
        @(negedge clk);
        check_quiet("reset_over_start");
        bus.start = 1'b0;
        bus.pc    = 16'h0;
        step();
        areset = 1'b0;
        step();
        @(negedge clk);
        check_quiet("post_reset_idle");
    endtask

    task automatic test_basic();
        int c;
        step();
        c = cyc;
        push_fetch(16'h0010, c, 5, 5, 1);
        bus.start = 1'b1;
        bus.pc    = 16'h0010;
        step();
        bus.start = 1'b0;
        bus.pc    = 16'h0;
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            fails++; $display("FAIL basic_rd_a busy/done got %b%b want 10", bus.busy, bus.done);
        end
        wait_idle("basic");
    endtask

    task automatic test_wrap();
        step();
        push_fetch(16'hFFFF, cyc, 5, 5, 1);
        bus.start = 1'b1;
        bus.pc    = 16'hFFFF;
        step();
        bus.start = 1'b0;
        wait_idle("wrap");
    endtask

    task automatic test_back_to_back();
        int c;
        bit eb;
        step();
        c = cyc;
        push_fetch(16'h0010, c, 5, 5, 1);
        push_fetch(16'h0010, c + 7, 5, 5, 1);
        bus.start = 1'b1;
        bus.pc    = 16'h0010;
        for (int i = 0; i <= 14; i++) begin
            @(negedge clk);
            eb = (i >= 1) && (i <= 13) && (i != 7);
            tests++;
            if (bus.busy !== eb) begin fails++; $display("FAIL b2b_busy i=%0d got %b want %b", i, bus.busy, eb); end
            if (i == 13) bus.start = 1'b0;
        end
        wait_idle("b2b");
    endtask

    task automatic test_abort();
        step();
        push_fetch(16'h0010, cyc, 3, 2, 0);
        bus.start = 1'b1;
        bus.pc    = 16'h0010;
        step();
        bus.start = 1'b0;
        step();
        step();
        areset = 1'b1;
        step();
        areset = 1'b0;
        @(negedge clk);
        check_quiet("abort_idle");
        tests++;
        if (stb_q.size() != 0 || addr_q.size() != 0) begin
            fails++; $display("FAIL abort_pending got set=%0d rd=%0d want 0", stb_q.size(), addr_q.size());
            stb_q.delete(); addr_q.delete();
        end
        repeat (8) @(negedge clk);
        step();
        push_fetch(16'h0010, cyc, 5, 5, 1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_idle("after_abort");
    endtask

    task automatic test_ignore_start();
        step();
        push_fetch(16'h0010, cyc, 5, 5, 1);
        bus.start = 1'b1;
        bus.pc    = 16'h0010;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        bus.start = 1'b1;
        bus.pc    = 16'h0040;
        step();
        bus.start = 1'b0;
        wait_idle("ignore");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (bus.busy !== 1'b0) begin fails++; $display("FAIL ignore_queued i=%0d busy got %b want 0", i, bus.busy); end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 7 + 3);
        mem[16'h0010] = 16'h0040; mem[16'h0011] = 16'h0041; mem[16'h0012] = 16'h0020;
        mem[16'h0040] = 16'h0005; mem[16'h0041] = 16'h0007;
        mem[16'hFFFF] = 16'h0100; mem[16'h0000] = 16'h0101; mem[16'h0001] = 16'h0002;
        mem[16'h0100] = 16'h1234; mem[16'h0101] = 16'hBEEF;
        bus.start = 1'b0;
        bus.pc    = 16'h0;
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_abort();
        test_ignore_start();
        repeat (3) @(negedge clk);
        tests++;
        if (done_q.size() != 0 || stb_q.size() != 0 || addr_q.size() != 0) begin
            fails++; $display("FAIL final_queues got done=%0d set=%0d rd=%0d want 0", done_q.size(), stb_q.size(), addr_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
